// File: rtl/servo_pos_ramp.sv
// -----------------------------------------------------------------------------
// servo_pos_ramp
//
// Command stage feeding the servo PWM generator. A target position arrives over
// a valid/ready handshake, is clamped to the legal servo range, and the signed
// duty command is slewed toward it by at most STEP once per PWM frame. After
// the command reaches the target the block dwells for HOLD_FRAMES frames
// before it accepts the next target.
//
// Ports
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   tgt_in     : signed target position, sampled only on an accepted transfer
//   tgt_valid  : target present
//   tgt_ready  : high while IDLE (block can accept a target)
//   PWM_cmd    : signed duty command, changes only on frame boundaries
//   busy       : high whenever the block is not IDLE
//   done       : one-cycle pulse on the first IDLE cycle after a settle
//   sat        : one-cycle pulse in the cycle after an accepted target was clamped
// -----------------------------------------------------------------------------
module servo_pos_ramp #(
    parameter int cant_bits   = 8,
    parameter int PERIOD      = 10000,
    parameter int STEP        = 2,
    parameter int MIN_POS     = 0,
    parameter int MAX_POS     = 127,
    parameter int RST_POS     = 64,
    parameter int HOLD_FRAMES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [cant_bits-1:0] tgt_in,
    input  logic                        tgt_valid,
    output logic                        tgt_ready,
    output logic signed [cant_bits-1:0] PWM_cmd,
    output logic                        busy,
    output logic                        done,
    output logic                        sat
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int SET_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [SET_W-1:0] HOLD_LD  = SET_W'(HOLD_FRAMES);
    localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
    localparam logic [SET_W-1:0] SET_ZERO = SET_W'(0);

    localparam logic signed [cant_bits-1:0] MIN_C  = cant_bits'(MIN_POS);
    localparam logic signed [cant_bits-1:0] MAX_C  = cant_bits'(MAX_POS);
    localparam logic signed [cant_bits-1:0] RST_C  = cant_bits'(RST_POS);
    localparam logic signed [cant_bits-1:0] STEP_C = cant_bits'(STEP);
    localparam logic signed [cant_bits:0]   STEP_X = (cant_bits + 1)'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAMP   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Limit a raw target to [MIN_POS, MAX_POS] using signed compares.
    function automatic logic signed [cant_bits-1:0] clamp_pos(
        input logic signed [cant_bits-1:0] v
    );
        logic signed [cant_bits-1:0] r;
        if (v < MIN_C) begin
            r = MIN_C;
        end else if (v > MAX_C) begin
            r = MAX_C;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // True when the raw target lies outside the legal range.
    function automatic logic is_clamped(
        input logic signed [cant_bits-1:0] v
    );
        return (v < MIN_C) || (v > MAX_C);
    endfunction

    state_t                      state_q,  state_d;
    logic [CNT_W-1:0]            frame_cnt_q;
    logic [SET_W-1:0]            settle_q, settle_d;
    logic signed [cant_bits-1:0] tgt_q,    tgt_d;
    logic signed [cant_bits-1:0] cmd_q,    cmd_d;
    logic                        done_q,   done_d;
    logic                        sat_q,    sat_d;

    logic                        frame_tick_s;
    logic signed [cant_bits-1:0] tgt_clamp_s;
    logic                        tgt_sat_s;
    logic signed [cant_bits:0]   diff_s;
    logic signed [cant_bits:0]   abs_diff_s;

    assign frame_tick_s = (frame_cnt_q == CNT_LAST);
    assign tgt_clamp_s  = clamp_pos(tgt_in);
    assign tgt_sat_s    = is_clamped(tgt_in);

    // Difference carried at one extra bit so that it can never overflow.
    assign diff_s     = {tgt_q[cant_bits-1], tgt_q} - {cmd_q[cant_bits-1], cmd_q};
    assign abs_diff_s = diff_s[cant_bits] ? -diff_s : diff_s;

    assign tgt_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign PWM_cmd   = cmd_q;
    assign done      = done_q;
    assign sat       = sat_q;

    // Free-running frame counter that wraps at PERIOD-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= CNT_ZERO;
        end else if (frame_tick_s) begin
            frame_cnt_q <= CNT_ZERO;
        end else begin
            frame_cnt_q <= frame_cnt_q + CNT_ONE;
        end
    end

    // State, command, latched target, settle counter and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            settle_q <= SET_ZERO;
            tgt_q    <= RST_C;
            cmd_q    <= RST_C;
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            tgt_q    <= tgt_d;
            cmd_q    <= cmd_d;
            done_q   <= done_d;
            sat_q    <= sat_d;
        end
    end

    // Next-state logic: accept/clamp in IDLE, slew on frame ticks in RAMP,
    // count down the dwell in SETTLE.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        tgt_d    = tgt_q;
        cmd_d    = cmd_q;
        done_d   = 1'b0;
        sat_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tgt_valid) begin
                    tgt_d = tgt_clamp_s;
                    sat_d = tgt_sat_s;
                    if (tgt_clamp_s == cmd_q) begin
                        state_d  = ST_SETTLE;
                        settle_d = HOLD_LD;
                    end else begin
                        state_d = ST_RAMP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RAMP: begin
                if (frame_tick_s) begin
                    if (abs_diff_s <= STEP_X) begin
                        // Final (possibly partial) step lands exactly on target.
                        cmd_d    = tgt_q;
                        state_d  = ST_SETTLE;
                        settle_d = HOLD_LD;
                    end else if (diff_s[cant_bits]) begin
                        cmd_d = cmd_q - STEP_C;
                    end else begin
                        cmd_d = cmd_q + STEP_C;
                    end
                end else begin
                    cmd_d = cmd_q;
                end
            end

            ST_SETTLE: begin
                if (settle_q == SET_ZERO) begin
                    // Zero dwell leaves on the very next clock.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (frame_tick_s) begin
                    settle_d = settle_q - SET_ONE;
                    if (settle_q == SET_ONE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end else begin
                    state_d = ST_SETTLE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                settle_d = SET_ZERO;
            end
        endcase
    end

endmodule
